enemy_wave_ctl: RTL

Central controller for a wave of N enemy units. It tracks which enemies are alive and latches their elimination pulses. A round-robin arbiter turns those eliminations into score increments, one per cycle. It also turns enemy-hero collisions into life loss with an invulnerability window, and sequences level-complete, respawn and game-over.

---
 rtl/enemy_wave_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 33 +++
 rtl/enemy_wave_ctl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/enemy_wave_pkg.sv
// Shared types and constants for the enemy wave controller: FSM encoding,
// score/timer widths and the saturating score adder.
package enemy_wave_pkg;

    localparam int SCORE_W = 24;
    localparam int TIMER_W = 12;
    localparam logic [SCORE_W-1:0] SCORE_MAX = 24'hFFFFFF;

    localparam logic [2:0] ST_IDLE_ENC         = 3'd0;
    localparam logic [2:0] ST_PLAYING_ENC      = 3'd1;
    localparam logic [2:0] ST_HIT_COOLDOWN_ENC = 3'd2;
    localparam logic [2:0] ST_LEVEL_DONE_ENC   = 3'd3;
    localparam logic [2:0] ST_GAME_OVER_ENC    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE         = ST_IDLE_ENC,
        ST_PLAYING      = ST_PLAYING_ENC,
        ST_HIT_COOLDOWN = ST_HIT_COOLDOWN_ENC,
        ST_LEVEL_DONE   = ST_LEVEL_DONE_ENC,
        ST_GAME_OVER    = ST_GAME_OVER_ENC
    } state_t;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [SCORE_W-1:0] b);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[SCORE_W] ? SCORE_MAX : sum[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the lowest requesting index at or
// after ptr, wrapping, as a one-hot vector plus its encoded index.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             grant_valid,
    output logic [PTR_W-1:0] grant_idx
);

    logic [PTR_W-1:0] idx_s;
    logic             take_s;

    // Scan from ptr upward with wrap; the first requester seen wins
    always_comb begin
        grant       = {N{1'b0}};
        grant_valid = 1'b0;
        grant_idx   = {PTR_W{1'b0}};
        idx_s       = {PTR_W{1'b0}};
        take_s      = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx_s        = PTR_W'((int'(ptr) + k) % N);
            take_s       = req[idx_s] & ~grant_valid;
            grant[idx_s] = take_s;
            grant_valid  = grant_valid | take_s;
            grant_idx    = take_s ? idx_s : grant_idx;
        end
    end

endmodule

// File: rtl/enemy_wave_ctl.sv
// Wave controller: alive tracking, kill-to-score arbitration, hit/lives handling
// and level/game sequencing. Optional level bonus: ENEMY_WAVE_CTL_LEVEL_BONUS_EN.
module enemy_wave_ctl
    import enemy_wave_pkg::*;
#(
    parameter int N_ENEMIES     = 4,
    parameter int KILL_POINTS   = 200,
    parameter int START_LIVES   = 3,
    parameter int INVULN_CYCLES = 120,
    parameter int LEVEL_PAUSE   = 60,
    parameter int LEVEL_BONUS   = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 game_start,
    input  logic [N_ENEMIES-1:0] enemy_kill,
    input  logic [N_ENEMIES-1:0] enemy_hit,
    output logic [N_ENEMIES-1:0] enemy_alive,
    output logic [N_ENEMIES-1:0] enemy_respawn,
    output logic [SCORE_W-1:0]   score,
    output logic [1:0]           lives,
    output logic                 hero_invuln,
    output logic                 level_done,
    output logic                 game_over
);

    localparam int                   PTR_W      = $clog2(N_ENEMIES);
    localparam logic [N_ENEMIES-1:0] ALL_ONES   = {N_ENEMIES{1'b1}};
    localparam logic [N_ENEMIES-1:0] ALL_ZERO   = {N_ENEMIES{1'b0}};
    localparam logic [SCORE_W-1:0]   KILL_PTS   = SCORE_W'(KILL_POINTS);
    localparam logic [TIMER_W-1:0]   INV_LAST   = TIMER_W'(INVULN_CYCLES - 1);
    localparam logic [TIMER_W-1:0]   PAUSE_LAST = TIMER_W'(LEVEL_PAUSE - 1);
    localparam logic [1:0]           LIVES_INIT = 2'(START_LIVES);

    if (N_ENEMIES < 2 || N_ENEMIES > 8 || START_LIVES < 1 || START_LIVES > 3 ||
        INVULN_CYCLES < 1 || INVULN_CYCLES > 4095 || LEVEL_PAUSE < 1 || LEVEL_PAUSE > 4095 ||
        KILL_POINTS < 0 || LEVEL_BONUS < 0) begin : g_param_range
        $error("enemy_wave_ctl: parameter out of range");
    end

    state_t               state_r, state_nx_s;
    logic [N_ENEMIES-1:0] pending_r;
    logic [PTR_W-1:0]     rr_ptr_r, ptr_nx_s;
    logic [TIMER_W-1:0]   timer_r, timer_nx_s;
    logic [1:0]           lives_nx_s;
    logic                 kill_window_s, hit_s, respawn_all_s;
    logic [N_ENEMIES-1:0] kill_cap_s, req_s, grant_s, alive_nx_s;
    logic                 grant_valid_s, take_grant_s, add_en_s;
    logic [PTR_W-1:0]     grant_idx_s;
    logic [SCORE_W-1:0]   add_val_s, score_sum_s;

    // Kill capture window, arbiter requests and qualified collisions
    always_comb begin
        kill_window_s = (state_r == ST_PLAYING) || (state_r == ST_HIT_COOLDOWN);
        kill_cap_s    = kill_window_s ? (enemy_kill & enemy_alive) : ALL_ZERO;
        req_s         = (state_r == ST_IDLE) ? ALL_ZERO : (pending_r | kill_cap_s);
        hit_s         = |(enemy_hit & enemy_alive & ~enemy_kill);
    end

    rr_arbiter #(
        .N     (N_ENEMIES),
        .PTR_W (PTR_W)
    ) u_score_arb (
        .req         (req_s),
        .ptr         (rr_ptr_r),
        .grant       (grant_s),
        .grant_valid (grant_valid_s),
        .grant_idx   (grant_idx_s)
    );

    // Next-state, timer and lives; game_start is applied in the register block
    always_comb begin
        state_nx_s    = state_r;
        timer_nx_s    = timer_r;
        lives_nx_s    = lives;
        respawn_all_s = 1'b0;
        case (state_r)
            ST_IDLE: state_nx_s = ST_IDLE;
            ST_PLAYING: begin
                if (hit_s) begin
                    lives_nx_s = lives - 2'd1;
                    if (lives_nx_s == 2'd0) begin
                        state_nx_s = ST_GAME_OVER;
                    end else begin
                        timer_nx_s = {TIMER_W{1'b0}};
                        state_nx_s = ST_HIT_COOLDOWN;
                    end
                end else if (enemy_alive == ALL_ZERO && pending_r == ALL_ZERO) begin
                    timer_nx_s = {TIMER_W{1'b0}};
                    state_nx_s = ST_LEVEL_DONE;
                end else begin
                    state_nx_s = ST_PLAYING;
                end
            end
            ST_HIT_COOLDOWN: begin
                if (tick) begin
                    if (timer_r == INV_LAST) state_nx_s = ST_PLAYING;
                    else                     timer_nx_s = timer_r + TIMER_W'(1);
                end else begin
                    timer_nx_s = timer_r;
                end
            end
            ST_LEVEL_DONE: begin
                if (tick) begin
                    if (timer_r == PAUSE_LAST) begin
                        state_nx_s    = ST_PLAYING;
                        respawn_all_s = 1'b1;
                    end else begin
                        timer_nx_s = timer_r + TIMER_W'(1);
                    end
                end else begin
                    timer_nx_s = timer_r;
                end
            end
            ST_GAME_OVER: state_nx_s = ST_GAME_OVER;
            default:      state_nx_s = ST_IDLE;
        endcase
    end

    // Alive mask update and round-robin pointer advance
    always_comb begin
        if (state_nx_s == ST_GAME_OVER)  alive_nx_s = ALL_ZERO;
        else if (respawn_all_s)          alive_nx_s = ALL_ONES;
        else if (kill_window_s)          alive_nx_s = enemy_alive & ~enemy_kill;
        else                             alive_nx_s = enemy_alive;
        ptr_nx_s = (grant_idx_s == PTR_W'(N_ENEMIES - 1)) ? {PTR_W{1'b0}}
                                                          : grant_idx_s + PTR_W'(1);
    end

`ifdef ENEMY_WAVE_CTL_LEVEL_BONUS_EN
    localparam logic [SCORE_W-1:0] BONUS_PTS = SCORE_W'(LEVEL_BONUS);
    logic enter_done_s;

    // Shared score adder: the level bonus pre-empts a kill grant for one cycle
    always_comb begin
        enter_done_s = (state_r == ST_PLAYING) && (state_nx_s == ST_LEVEL_DONE);
        take_grant_s = grant_valid_s & ~enter_done_s;
        add_en_s     = enter_done_s | take_grant_s;
        add_val_s    = enter_done_s ? BONUS_PTS : KILL_PTS;
        score_sum_s  = sat_add(score, add_val_s);
    end
`else
    // Score adder fed only by arbiter grants
    always_comb begin
        take_grant_s = grant_valid_s;
        add_en_s     = grant_valid_s;
        add_val_s    = KILL_PTS;
        score_sum_s  = sat_add(score, add_val_s);
    end
`endif

    // State and output registers; game_start overrides every other event
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            pending_r     <= ALL_ZERO;
            rr_ptr_r      <= {PTR_W{1'b0}};
            timer_r       <= {TIMER_W{1'b0}};
            enemy_alive   <= ALL_ZERO;
            enemy_respawn <= ALL_ZERO;
            score         <= {SCORE_W{1'b0}};
            lives         <= 2'd0;
            hero_invuln   <= 1'b0;
            level_done    <= 1'b0;
            game_over     <= 1'b0;
        end else if (game_start) begin
            state_r       <= ST_PLAYING;
            pending_r     <= ALL_ZERO;
            rr_ptr_r      <= {PTR_W{1'b0}};
            timer_r       <= {TIMER_W{1'b0}};
            enemy_alive   <= ALL_ONES;
            enemy_respawn <= ALL_ONES;
            score         <= {SCORE_W{1'b0}};
            lives         <= LIVES_INIT;
            hero_invuln   <= 1'b0;
            level_done    <= 1'b0;
            game_over     <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            pending_r     <= take_grant_s ? (req_s & ~grant_s) : req_s;
            rr_ptr_r      <= take_grant_s ? ptr_nx_s : rr_ptr_r;
            timer_r       <= timer_nx_s;
            enemy_alive   <= alive_nx_s;
            enemy_respawn <= respawn_all_s ? ALL_ONES : ALL_ZERO;
            score         <= add_en_s ? score_sum_s : score;
            lives         <= lives_nx_s;
            hero_invuln   <= (state_nx_s == ST_HIT_COOLDOWN);
            level_done    <= (state_nx_s == ST_LEVEL_DONE);
            game_over     <= (state_nx_s == ST_GAME_OVER);
        end
    end

endmodule
